// File: rtl/hvac_control_fsm_pkg.sv
// Shared definitions for the HVAC relay state machine: state codes, mode
// encodings and the temperature range.
package hvac_control_fsm_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        HEAT    = 3'd1,
        COOL    = 3'd2,
        OVERRUN = 3'd3,
        LOCKOUT = 3'd4
    } hvac_state_e;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_HEAT = 2'b01;
    localparam logic [1:0] MODE_COOL = 2'b10;
    localparam logic [1:0] MODE_AUTO = 2'b11;

    localparam logic [7:0] TEMP_MAX = 8'd99;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/hvac_control_fsm_tick_gen.sv
// Free-running slow-timebase divider: one registered 1-clk tick every
// TICK_DIV cycles, first tick consumed on cycle TICK_DIV after reset.
module hvac_control_fsm_tick_gen #(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic clk,
    input  logic Reset,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(TICK_DIV);

    logic [DIV_W-1:0] div_r;
    logic             tick_r;

    // Divider counter wraps at TICK_DIV-1 and is never restarted by consumers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            div_r <= '0;
        end else if (div_r == DIV_W'(TICK_DIV - 1)) begin
            div_r <= '0;
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // Tick is raised one cycle early so the registered pulse lands on the last divider slot.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= (div_r == DIV_W'(TICK_DIV - 2));
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/hvac_control_fsm.sv
// Protected HVAC relay controller: hysteresis, minimum run time, fan overrun
// and post-run lockout, with outputs registered from the next state.
module hvac_control_fsm
    import hvac_control_fsm_pkg::*;
#(
    parameter int unsigned TICK_DIV          = 100000000,
    parameter int unsigned HYST              = 1,
    parameter int unsigned MIN_RUN_TICKS     = 60,
    parameter int unsigned FAN_OVERRUN_TICKS = 30,
    parameter int unsigned MIN_OFF_TICKS     = 120
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Enable,
    input  logic [1:0] Mode,
    input  logic [7:0] CurrentTemp,
    input  logic [7:0] TargetTemp,
    output logic       HeatOn,
    output logic       CoolOn,
    output logic       FanOn,
    output logic [2:0] State
);

    localparam int unsigned CNT_W =
        $clog2(max3(MIN_RUN_TICKS, FAN_OVERRUN_TICKS, MIN_OFF_TICKS)) + 1;

    hvac_state_e       state_r;
    hvac_state_e       state_next_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_inc_s;
    logic              tick_s;
    logic [8:0]        cur_s;
    logic [8:0]        tgt_s;
    logic [8:0]        hyst_s;
    logic              heat_req_s;
    logic              cool_req_s;
    logic              sat_heat_s;
    logic              sat_cool_s;
    logic              run_done_s;
    logic              heat_on_r;
    logic              cool_on_r;
    logic              fan_on_r;

    hvac_control_fsm_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .Reset (Reset),
        .tick  (tick_s)
    );

    assign cur_s      = {1'b0, CurrentTemp};
    assign tgt_s      = {1'b0, TargetTemp};
    assign hyst_s     = 9'(HYST);
    assign heat_req_s = Enable & Mode[0] & ((cur_s + hyst_s) < tgt_s);
    assign cool_req_s = Enable & Mode[1] & (cur_s > (tgt_s + hyst_s));
    assign sat_heat_s = (cur_s >= tgt_s);
    assign sat_cool_s = (cur_s <= tgt_s);
    assign run_done_s = (cnt_r >= CNT_W'(MIN_RUN_TICKS));
    assign cnt_inc_s  = cnt_r + CNT_W'(1);

    // Next-state decode; unused codes fall back to IDLE.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (heat_req_s) begin
                    state_next_s = HEAT;
                end else if (cool_req_s) begin
                    state_next_s = COOL;
                end else begin
                    state_next_s = IDLE;
                end
            end
            HEAT: begin
                if (!Enable || !Mode[0] || (run_done_s && sat_heat_s)) begin
                    state_next_s = OVERRUN;
                end else begin
                    state_next_s = HEAT;
                end
            end
            COOL: begin
                if (!Enable || !Mode[1] || (run_done_s && sat_cool_s)) begin
                    state_next_s = OVERRUN;
                end else begin
                    state_next_s = COOL;
                end
            end
            OVERRUN: begin
                if (tick_s && (cnt_inc_s == CNT_W'(FAN_OVERRUN_TICKS))) begin
                    state_next_s = LOCKOUT;
                end else begin
                    state_next_s = OVERRUN;
                end
            end
            LOCKOUT: begin
                if (tick_s && (cnt_inc_s == CNT_W'(MIN_OFF_TICKS))) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = LOCKOUT;
                end
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Per-state tick counter; saturates so a long HEAT/COOL run cannot wrap below MIN_RUN.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            cnt_r <= '0;
        end else if (state_next_s != state_r) begin
            cnt_r <= '0;
        end else if (tick_s && !(&cnt_r)) begin
            cnt_r <= cnt_inc_s;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Relay outputs decoded from the next state so they switch with State.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            heat_on_r <= 1'b0;
            cool_on_r <= 1'b0;
            fan_on_r  <= 1'b0;
        end else begin
            heat_on_r <= (state_next_s == HEAT);
            cool_on_r <= (state_next_s == COOL);
            fan_on_r  <= (state_next_s == HEAT) || (state_next_s == COOL) ||
                         (state_next_s == OVERRUN);
        end
    end

    assign HeatOn = heat_on_r;
    assign CoolOn = cool_on_r;
    assign FanOn  = fan_on_r;
    assign State  = state_r;

endmodule

// File: tb/tb_hvac_control_fsm.sv
// Scoreboard bench for hvac_control_fsm with a small tick-timed behavioural model
// plus directed checks from the reduced-timing test plan.
module tb_hvac_control_fsm;

    localparam int TD = 4;
    localparam int HY = 1;
    localparam int MR = 3;
    localparam int FO = 2;
    localparam int MO = 2;

    logic       clk;
    logic       Reset;
    logic       Enable;
    logic [1:0] Mode;
    logic [7:0] CurrentTemp;
    logic [7:0] TargetTemp;
    logic       HeatOn;
    logic       CoolOn;
    logic       FanOn;
    logic [2:0] State;

    typedef struct {
        int st;
        int heat;
        int cool;
        int fan;
    } exp_t;

    exp_t sb_q[$];

    int total;
    int bad;
    int m_state;
    int m_cnt;
    int m_edges;

    hvac_control_fsm #(
        .TICK_DIV          (TD),
        .HYST              (HY),
        .MIN_RUN_TICKS     (MR),
        .FAN_OVERRUN_TICKS (FO),
        .MIN_OFF_TICKS     (MO)
    ) dut (
        .clk         (clk),
        .Reset       (Reset),
        .Enable      (Enable),
        .Mode        (Mode),
        .CurrentTemp (CurrentTemp),
        .TargetTemp  (TargetTemp),
        .HeatOn      (HeatOn),
        .CoolOn      (CoolOn),
        .FanOn       (FanOn),
        .State       (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input int obs, input int exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_cnt   = 0;
        m_edges = 0;
    endtask

    // One clock edge: predict, push, advance, pop and compare.
    task automatic step();
        bit   tk;
        bit   hreq;
        bit   creq;
        bit   sh;
        bit   sc;
        int   nxt;
        exp_t e;
        exp_t g;
        tk   = ((m_edges + 1) % TD) == 0;
        hreq = Enable && Mode[0] && ((int'(CurrentTemp) + HY) < int'(TargetTemp));
        creq = Enable && Mode[1] && (int'(CurrentTemp) > (int'(TargetTemp) + HY));
        sh   = int'(CurrentTemp) >= int'(TargetTemp);
        sc   = int'(CurrentTemp) <= int'(TargetTemp);
        nxt  = m_state;
        case (m_state)
            0: if (hreq) nxt = 1; else if (creq) nxt = 2;
            1: if (!Enable || !Mode[0] || (m_cnt >= MR && sh)) nxt = 3;
            2: if (!Enable || !Mode[1] || (m_cnt >= MR && sc)) nxt = 3;
            3: if (tk && (m_cnt + 1 == FO)) nxt = 4;
            4: if (tk && (m_cnt + 1 == MO)) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_state) m_cnt = 0;
        else if (tk) m_cnt++;
        m_state = nxt;
        m_edges++;
        e.st   = nxt;
        e.heat = (nxt == 1) ? 1 : 0;
        e.cool = (nxt == 2) ? 1 : 0;
        e.fan  = (nxt >= 1 && nxt <= 3) ? 1 : 0;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check_value("sb_empty", 0, 1);
        end else begin
            g = sb_q.pop_front();
            check_value("sb_state", int'(State), g.st);
            check_value("sb_heat", int'(HeatOn), g.heat);
            check_value("sb_cool", int'(CoolOn), g.cool);
            check_value("sb_fan", int'(FanOn), g.fan);
            check_value("heat_cool_excl", int'(HeatOn & CoolOn), 0);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_outs(input string tag, input int st, input int h, input int c,
                              input int f);
        check_value({tag, "_state"}, int'(State), st);
        check_value({tag, "_heat"}, int'(HeatOn), h);
        check_value({tag, "_cool"}, int'(CoolOn), c);
        check_value({tag, "_fan"}, int'(FanOn), f);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        Reset       = 1'b1;
        Enable      = 1'b1;
        Mode        = 2'b11;
        TargetTemp  = 8'd72;
        CurrentTemp = 8'd71;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 0, 0, 0, 0);
        Reset = 1'b0;
        model_reset();

        // Hysteresis: 71 vs 72 holds, 70 calls for heat.
        run(3);
        check_outs("hyst_idle", 0, 0, 0, 0);
        CurrentTemp = 8'd70;
        run(1);
        check_outs("heat_enter", 1, 1, 0, 1);

        // Minimum run, overrun, lockout with a held-off request.
        run(4);
        CurrentTemp = 8'd72;
        run(8);
        check_outs("min_run_hold", 1, 1, 0, 1);
        run(1);
        check_outs("overrun_enter", 3, 0, 0, 1);
        run(6);
        check_outs("overrun_hold", 3, 0, 0, 1);
        run(1);
        check_outs("lockout_enter", 4, 0, 0, 0);
        CurrentTemp = 8'd60;
        run(7);
        check_outs("lockout_hold", 4, 0, 0, 0);
        run(1);
        check_outs("lockout_exit", 0, 0, 0, 0);
        run(1);
        check_outs("heat_after_lock", 1, 1, 0, 1);

        // Forced shutdown one tick into HEAT.
        run(3);
        Enable = 1'b0;
        run(1);
        check_outs("shutdown", 3, 0, 0, 1);
        run(6);
        check_outs("shutdown_fan", 3, 0, 0, 1);
        run(1);
        check_outs("shutdown_lock", 4, 0, 0, 0);
        run(8);
        check_outs("shutdown_idle", 0, 0, 0, 0);

        // Cool request masked by heat-only mode, then accepted in cool mode.
        Enable      = 1'b1;
        Mode        = 2'b01;
        CurrentTemp = 8'd75;
        run(3);
        check_outs("cool_masked", 0, 0, 0, 0);
        Mode = 2'b10;
        run(1);
        check_outs("cool_enter", 2, 0, 1, 1);
        run(2);

        // Asynchronous reset between edges mid-COOL.
        #3;
        Reset = 1'b1;
        #1;
        check_outs("async_reset", 0, 0, 0, 0);
        @(posedge clk);
        #1;
        Reset = 1'b0;
        model_reset();

        // Tick phase after reset: enter HEAT, shut down, overrun ends on edge 8.
        Mode        = 2'b11;
        CurrentTemp = 8'd60;
        run(1);
        check_outs("post_rst_heat", 1, 1, 0, 1);
        Enable = 1'b0;
        run(1);
        check_outs("post_rst_ovr", 3, 0, 0, 1);
        run(5);
        check_outs("post_rst_ovr_hold", 3, 0, 0, 1);
        run(1);
        check_outs("post_rst_lock", 4, 0, 0, 0);

        // Random input traffic checked against the model.
        for (int k = 0; k < 40; k++) begin
            Enable      = ($urandom_range(0, 7) != 0);
            Mode        = 2'($urandom_range(0, 3));
            TargetTemp  = 8'($urandom_range(70, 74));
            CurrentTemp = 8'($urandom_range(66, 78));
            run(3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
